warp_dispatcher: RTL

- Upstream stage of the SIMD core: accepts kernel descriptors (kernel_t) from the host/testbench and queues them in a small FIFO.
- Launches one warp at a time onto the core by driving the core's kernel input and a per-launch core reset.
- Watches the core's finish handshake; reports completion or timeout per warp and keeps completion statistics.

---
 rtl/warp_dispatcher_pkg.sv | 13 +
 rtl/warp_dispatcher_if.sv | 37 +++
 rtl/warp_dispatcher.sv | 117 +++++++++++
 3 files changed

// File: rtl/warp_dispatcher_pkg.sv
// Shared types for the warp dispatcher: the kernel descriptor handed to the SIMD core.
package warp_dispatcher_pkg;

  typedef struct packed {
    logic [3:0]  warp_id;
    logic [31:0] start_pc;
    logic [7:0]  thread_count;
  } kernel_t;

  // Reserved warp id: never queued, also the core's "nothing finished" marker.
  localparam logic [3:0] WARP_NONE = 4'hF;

endpackage

// File: rtl/warp_dispatcher_if.sv
// Bundle of submit, core-control, completion and status signals around the dispatcher.
interface warp_dispatcher_if #(
  parameter int QUEUE_DEPTH = 4
);
  import warp_dispatcher_pkg::*;

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic          submit_valid;
  kernel_t       submit_kernel;
  logic          submit_ready;
  kernel_t       kernel_out;
  logic          core_rst;
  logic          core_finished;
  logic [3:0]    core_finished_warp_id;
  logic          done_valid;
  logic [3:0]    done_warp_id;
  logic          done_timeout;
  logic          busy;
  logic [CW-1:0] queue_count;
  logic [15:0]   completed_count;

  // Dispatcher side.
  modport master (
    input  submit_valid, submit_kernel, core_finished, core_finished_warp_id,
    output submit_ready, kernel_out, core_rst, done_valid, done_warp_id,
           done_timeout, busy, queue_count, completed_count
  );

  // Host / core side.
  modport slave (
    output submit_valid, submit_kernel, core_finished, core_finished_warp_id,
    input  submit_ready, kernel_out, core_rst, done_valid, done_warp_id,
           done_timeout, busy, queue_count, completed_count
  );

endinterface

// File: rtl/warp_dispatcher.sv
// Queues kernel descriptors and launches one warp at a time onto the SIMD core,
// reporting completion or timeout for each warp.
module warp_dispatcher
  import warp_dispatcher_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic            clk,
  input logic            rst,
  warp_dispatcher_if.master bus
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

  state_t        state;
  kernel_t       fifo [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  logic          push;
  logic          pop;
  logic          finish_hit;
  logic          timer_expired;

  // The reserved id completes the handshake but is dropped instead of queued.
  assign bus.submit_ready = (count < CW'(QUEUE_DEPTH));
  assign push          = bus.submit_valid && bus.submit_ready &&
                         (bus.submit_kernel.warp_id != WARP_NONE);
  assign pop           = (state == IDLE) && (count != '0);
  assign bus.queue_count = count;
  assign bus.busy      = (state != IDLE) || (count != '0);
  assign finish_hit    = bus.core_finished &&
                         (bus.core_finished_warp_id == bus.kernel_out.warp_id);
  assign timer_expired = (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= bus.submit_kernel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Launch sequencing; every core-facing and completion output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      bus.kernel_out      <= '0;
      bus.core_rst        <= 1'b1;
      bus.done_valid      <= 1'b0;
      bus.done_warp_id    <= WARP_NONE;
      bus.done_timeout    <= 1'b0;
      bus.completed_count <= 16'h0000;
      timer               <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.core_rst <= 1'b1;
          if (pop) begin
            bus.kernel_out <= fifo[rd_ptr];
            state          <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer        <= '0;
          bus.core_rst <= 1'b0;
          state        <= RUN;
        end
        RUN: begin
          timer <= timer + 1'b1;
          // A matching finish takes priority over an expiring timer.
          if (finish_hit || timer_expired) begin
            state            <= DONE;
            bus.core_rst     <= 1'b1;
            bus.done_valid   <= 1'b1;
            bus.done_warp_id <= bus.kernel_out.warp_id;
            bus.done_timeout <= !finish_hit;
          end
        end
        DONE: begin
          if (!bus.done_timeout && (bus.completed_count != 16'hFFFF)) begin
            bus.completed_count <= bus.completed_count + 16'h0001;
          end
          bus.done_valid   <= 1'b0;
          bus.done_warp_id <= WARP_NONE;
          bus.done_timeout <= 1'b0;
          state            <= IDLE;
        end
        default: begin
          bus.core_rst <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
